// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line/parity constants
// used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator shared by the TX frame builder and the RX
// parity check: even parity yields the XOR of the data, odd its complement.
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_par_typ,
   output logic                  o_par
);

   assign o_par = (i_par_typ == PAR_ODD) ? ~^i_data : ^i_data;

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first payload, optional parity,
// stop bit, one bit per CLK cycle, with registered TX_OUT and Busy.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   uart_state_e           r_state;
   uart_state_e           w_next_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      w_bit_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_shadow;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_accept;
   logic                  w_par_bit;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;

   assign w_accept = (r_state == IDLE) && Data_Valid;

   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_calc (
      .i_data    (r_shadow),
      .i_par_typ (r_par_typ),
      .o_par     (w_par_bit)
   );

   // Outputs are registered from the next-state decode so the line changes
   // on the same edge as the state it belongs to.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_tx      <= STOP_BIT;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_shadow  <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= PAR_EVEN;
      end else if (w_accept) begin
         r_shadow  <= P_DATA;
         r_par_en  <= PAR_EN;
         r_par_typ <= PAR_TYP;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      case (r_state)
         IDLE: begin
            if (Data_Valid) begin
               w_next_state  = START;
               w_bit_cnt_nxt = '0;
            end
         end
         START: begin
            w_next_state  = DATA;
            w_bit_cnt_nxt = '0;
         end
         DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_next_state = r_par_en ? PARITY : STOP;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         PARITY:  w_next_state = STOP;
         STOP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_tx_nxt   = STOP_BIT;
      w_busy_nxt = 1'b1;
      case (w_next_state)
         IDLE: begin
            w_tx_nxt   = STOP_BIT;
            w_busy_nxt = 1'b0;
         end
         START:   w_tx_nxt = START_BIT;
         DATA:    w_tx_nxt = r_shadow[w_bit_cnt_nxt];
         PARITY:  w_tx_nxt = w_par_bit;
         STOP:    w_tx_nxt = STOP_BIT;
         default: begin
            w_tx_nxt   = STOP_BIT;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   assign TX_OUT = r_tx;
   assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and randomized frames compared cycle by cycle
// against an expected bit stream built from the frame-format rules.
module tb_uart_tx;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   uart_tx #(
      .DATA_WIDTH (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk($sformatf("%s idle%0d tx", tag, i), TX_OUT, 1'b1);
         chk($sformatf("%s idle%0d busy", tag, i), Busy, 1'b0);
      end
   endtask

   // Drives an accept at the current negedge, then checks every frame cycle
   // plus the idle cycle after the stop bit. inj_idx pulses a stray strobe
   // with 8'hFF during that frame cycle; abort_idx resets at that cycle.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input int inj_idx, input int abort_idx, input string tag);
      bit q[$];
      bit par;
      q = {};
      q.push_back(1'b0);
      for (int b = 0; b < 8; b++) q.push_back(d[b]);
      par = (($countones(d) % 2) == 1) ^ ptyp;
      if (pen) q.push_back(par);
      q.push_back(1'b1);

      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
      @(posedge CLK);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge CLK);
         Data_Valid = (i == inj_idx);
         if (i == inj_idx) P_DATA = 8'hFF;
         else begin
            P_DATA  = 8'($urandom);
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
         end
         chk($sformatf("%s bit%0d tx", tag, i), TX_OUT, q[i]);
         chk($sformatf("%s bit%0d busy", tag, i), Busy, 1'b1);
         if (i == abort_idx) begin
            RST = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            RST = 1'b0;
            chk($sformatf("%s abort tx", tag), TX_OUT, 1'b1);
            chk($sformatf("%s abort busy", tag), Busy, 1'b0);
            return;
         end
      end
      @(negedge CLK);
      Data_Valid = 1'b0;
      chk($sformatf("%s post tx", tag), TX_OUT, 1'b1);
      chk($sformatf("%s post busy", tag), Busy, 1'b0);
   endtask

   initial begin
      RST        = 1'b1;
      Data_Valid = 1'b0;
      P_DATA     = 8'h00;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;

      // Reset held for two cycles
      @(posedge CLK);
      @(negedge CLK);
      chk("reset c0 tx", TX_OUT, 1'b1);
      chk("reset c0 busy", Busy, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      chk("reset c1 tx", TX_OUT, 1'b1);
      chk("reset c1 busy", Busy, 1'b0);
      RST = 1'b0;
      idle(2, "after_reset");

      send_frame(8'hA5, 1'b0, 1'b0, -1, -1, "noparA5");
      idle(1, "gap1");
      send_frame(8'h03, 1'b1, 1'b0, -1, -1, "even03");
      send_frame(8'h03, 1'b1, 1'b1, -1, -1, "odd03");
      send_frame(8'h07, 1'b1, 1'b0, -1, -1, "even07");

      // Stray strobe during bit 3 must be dropped
      send_frame(8'h00, 1'b0, 1'b0, 4, -1, "ignored");
      idle(14, "no_second");

      // Back-to-back: second accept on the first Busy-low cycle
      send_frame(8'h5A, 1'b0, 1'b0, -1, -1, "b2b_first");
      send_frame(8'($urandom), 1'b1, 1'($urandom), -1, -1, "b2b_second");

      // Strobe coincident with reset is not accepted
      RST        = 1'b1;
      Data_Valid = 1'b1;
      P_DATA     = 8'h55;
      @(posedge CLK);
      @(negedge CLK);
      RST        = 1'b0;
      Data_Valid = 1'b0;
      idle(4, "rst_dv");

      // Reset in the middle of a data bit
      send_frame(8'($urandom), 1'b1, 1'b0, -1, 5, "abort");
      idle(2, "after_abort");
      send_frame(8'h81, 1'b0, 1'b0, -1, -1, "fresh81");
      send_frame(8'h81, 1'b1, 1'b1, -1, -1, "fresh81odd");

      for (int n = 0; n < 30; n++) begin
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), -1, -1,
                    $sformatf("rand%0d", n));
         idle($urandom_range(0, 3), $sformatf("rgap%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
